// File: rtl/bhtbtb_update_arbiter_if.sv
// Fetch-lookup and branch-resolution-update handshake bundle for bhtbtb_update_arbiter.
// master = IFU/backend side, slave = arbiter side.
interface bhtbtb_update_arbiter_if;
    logic        lkp_valid;
    logic [63:0] lkp_pc;
    logic        lkp_ready;
    logic        lkp_rsp_valid;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_ready;

    modport master (
        output lkp_valid, lkp_pc, upd_valid, upd_pc, upd_taken, upd_target,
        input  lkp_ready, lkp_rsp_valid, upd_ready
    );

    modport slave (
        input  lkp_valid, lkp_pc, upd_valid, upd_pc, upd_taken, upd_target,
        output lkp_ready, lkp_rsp_valid, upd_ready
    );
endinterface

// File: rtl/bhtbtb_update_arbiter.sv
// Shares the single-port BHT/BTB SRAM between fetch lookups and buffered RMW branch updates.
// Optional starvation guard enabled by defining UPD_STARVE_GUARD_EN.
module bhtbtb_update_arbiter #(
    parameter int IDX_W        = 6,
    parameter int TAG_W        = 8,
    parameter int UPD_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    bhtbtb_update_arbiter_if.slave bus,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic                  sram_btb_we,
    output logic [IDX_W-1:0]      sram_addr,
    output logic [31:0]           sram_bht_wdata,
    output logic [31:0]           sram_btb_wdata,
    output logic [TAG_W-1:0]      sram_tag_wdata,
    input  logic [31:0]           sram_bht_rdata
);
    localparam int PTR_W = $clog2(UPD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {IDLE, UPD_WR} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic [3:0]       slot;
        logic             taken;
        logic [31:0]      target;
    } upd_t;

    state_t           state_q, state_d;
    upd_t             fifo_q [UPD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    upd_t             upd_q;
    logic             lkp_rsp_valid_q;

    logic             full, empty, push, pop, force_upd, lkp_ready;
    upd_t             push_entry, head;
    logic [IDX_W-1:0] lkp_idx;
    logic [1:0]       old_ctr, new_ctr;
    logic             unused_pc_bits;

    assign full  = (count_q == CNT_W'(UPD_DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.upd_valid && !full;
    assign head  = fifo_q[rd_ptr_q];

    assign lkp_idx           = bus.lkp_pc[6 +: IDX_W];
    assign push_entry.idx    = bus.upd_pc[6 +: IDX_W];
    assign push_entry.tag    = bus.upd_pc[6+IDX_W +: TAG_W];
    assign push_entry.slot   = bus.upd_pc[5:2];
    assign push_entry.taken  = bus.upd_taken;
    assign push_entry.target = bus.upd_target;

    assign unused_pc_bits = ^{bus.lkp_pc[63:6+IDX_W], bus.lkp_pc[5:0],
                              bus.upd_pc[63:6+IDX_W+TAG_W], bus.upd_pc[1:0]};

    assign bus.lkp_ready     = lkp_ready;
    assign bus.upd_ready     = !full;
    assign bus.lkp_rsp_valid = lkp_rsp_valid_q;

`ifdef UPD_STARVE_GUARD_EN
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    logic [STV_W-1:0] starve_q, starve_d;

    assign force_upd = full || (starve_q == STV_W'(STARVE_LIMIT));

    // Counts lookups that won while an update sat queued; a pop restarts the window.
    always_comb begin
        starve_d = starve_q;
        if (pop)
            starve_d = '0;
        else if (state_q == IDLE && !empty && lkp_ready)
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end
`else
    logic [31:0] unused_starve_limit;
    assign unused_starve_limit = 32'(STARVE_LIMIT);
    assign force_upd = full;
`endif

    // Saturating 2-bit counter update on the slot picked by the latched update.
    assign old_ctr = sram_bht_rdata[{upd_q.slot, 1'b0} +: 2];
    assign new_ctr = upd_q.taken ? ((old_ctr == 2'b11) ? 2'b11 : old_ctr + 2'b01)
                                 : ((old_ctr == 2'b00) ? 2'b00 : old_ctr - 2'b01);

    assign sram_btb_wdata = upd_q.target;
    assign sram_tag_wdata = upd_q.tag;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        sram_en        = 1'b0;
        sram_we        = 1'b0;
        sram_btb_we    = 1'b0;
        sram_addr      = '0;
        sram_bht_wdata = sram_bht_rdata;
        lkp_ready      = 1'b0;
        pop            = 1'b0;
        state_d        = state_q;
        unique case (state_q)
            IDLE: begin
                if (force_upd || (!bus.lkp_valid && !empty)) begin
                    pop       = 1'b1;
                    sram_en   = 1'b1;
                    sram_addr = head.idx;
                    state_d   = UPD_WR;
                end else if (bus.lkp_valid) begin
                    lkp_ready = 1'b1;
                    sram_en   = 1'b1;
                    sram_addr = lkp_idx;
                end
            end
            UPD_WR: begin
                sram_en     = 1'b1;
                sram_we     = 1'b1;
                sram_btb_we = upd_q.taken;
                sram_addr   = upd_q.idx;
                sram_bht_wdata[{upd_q.slot, 1'b0} +: 2] = new_ctr;
                state_d     = IDLE;
            end
        endcase
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // NOTE: FIFO storage is deliberately not reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push) fifo_q[wr_ptr_q] <= push_entry;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            upd_q           <= '0;
            lkp_rsp_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            lkp_rsp_valid_q <= bus.lkp_valid && lkp_ready;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                upd_q    <= head;
            end
        end
    end
endmodule

// File: tb/tb_bhtbtb_update_arbiter.sv
// Scoreboard bench for bhtbtb_update_arbiter: expected SRAM accesses are queued by the
// stimulus and checked in order by a negedge monitor against a behavioural SRAM.
module tb_bhtbtb_update_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        sram_en, sram_we, sram_btb_we;
    logic [5:0]  sram_addr;
    logic [31:0] sram_bht_wdata, sram_btb_wdata, sram_bht_rdata;
    logic [7:0]  sram_tag_wdata;
    logic [31:0] mem [64];

    int n_pass   = 0;
    int n_checks = 0;

    typedef struct {
        bit          is_lkp;
        bit          we;
        bit          btb_we;
        logic [5:0]  addr;
        logic [31:0] bht;
        logic [31:0] btb;
        logic [7:0]  tag;
    } acc_t;

    acc_t exp_q[$];
    acc_t mon_e;
    bit   rsp_pending = 1'b0;

    always #5 clock = ~clock;

    bhtbtb_update_arbiter_if bus_if();

    bhtbtb_update_arbiter #(
        .IDX_W(6), .TAG_W(8), .UPD_DEPTH(4), .STARVE_LIMIT(8)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .bus            (bus_if),
        .sram_en        (sram_en),
        .sram_we        (sram_we),
        .sram_btb_we    (sram_btb_we),
        .sram_addr      (sram_addr),
        .sram_bht_wdata (sram_bht_wdata),
        .sram_btb_wdata (sram_btb_wdata),
        .sram_tag_wdata (sram_tag_wdata),
        .sram_bht_rdata (sram_bht_rdata)
    );

    // Behavioural single-port BHT array with one-cycle read latency, preloaded in reset.
    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[2]         <= 32'h0000_8003;
            mem[10]        <= 32'h0000_0080;
            mem[11]        <= 32'h0000_0000;
            mem[12]        <= 32'hC000_0000;
            mem[13]        <= 32'h1234_5678;
            mem[20]        <= 32'h0000_0004;
            sram_bht_rdata <= 32'h0;
        end else if (sram_en) begin
            if (sram_we) mem[sram_addr] <= sram_bht_wdata;
            else         sram_bht_rdata <= mem[sram_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        else             n_pass++;
    endtask

    function automatic void exp_rd(input logic [5:0] a, input bit lk);
        acc_t e;
        e.is_lkp = lk;  e.we = 1'b0; e.btb_we = 1'b0; e.addr = a;
        e.bht = '0;     e.btb = '0;  e.tag = '0;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_wr(input logic [5:0] a, input logic [31:0] bht,
                                   input bit bw, input logic [31:0] btb, input logic [7:0] tag);
        acc_t e;
        e.is_lkp = 1'b0; e.we = 1'b1; e.btb_we = bw; e.addr = a;
        e.bht = bht;     e.btb = btb; e.tag = tag;
        exp_q.push_back(e);
    endfunction

    // Monitor: every array access must match the head of the expected queue.
    always @(negedge clock) begin
        if (!reset_n) begin
            rsp_pending = 1'b0;
        end else begin
            if (rsp_pending || bus_if.lkp_rsp_valid)
                check("lkp_rsp_valid", bus_if.lkp_rsp_valid, rsp_pending);
            rsp_pending = 1'b0;
            if (sram_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_access: addr=%0d we=%0b, expected no access at %0t",
                             sram_addr, sram_we, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sram_we", sram_we, mon_e.we);
                    check("sram_addr", sram_addr, mon_e.addr);
                    check("lkp_ready", bus_if.lkp_ready, mon_e.is_lkp);
                    if (mon_e.we) begin
                        check("bht_wdata", sram_bht_wdata, mon_e.bht);
                        check("btb_we", sram_btb_we, mon_e.btb_we);
                        if (mon_e.btb_we) begin
                            check("btb_wdata", sram_btb_wdata, mon_e.btb);
                            check("tag_wdata", sram_tag_wdata, mon_e.tag);
                        end
                    end
                    rsp_pending = mon_e.is_lkp;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        check("drain_outstanding", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    logic [63:0] d_pc  [4] = '{64'h5A28C, 64'h012FC, 64'hFF33C, 64'hFFFF_0000_0003_C360};
    logic        d_tk  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] d_tgt [4] = '{32'hAAAA_0000, 32'h0, 32'h0000_2000, 32'hDEAD_BEE0};

    initial begin
        reset_n              = 1'b0;
        bus_if.lkp_valid     = 1'b0;
        bus_if.lkp_pc        = '0;
        bus_if.upd_valid     = 1'b0;
        bus_if.upd_pc        = '0;
        bus_if.upd_taken     = 1'b0;
        bus_if.upd_target    = '0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_sram_en", sram_en, 0);
        check("rst_sram_we", sram_we, 0);
        check("rst_btb_we", sram_btb_we, 0);
        check("rst_upd_ready", bus_if.upd_ready, 1);
        check("rst_lkp_rsp_valid", bus_if.lkp_rsp_valid, 0);
        reset_n = 1'b1;

        // Idle lookup at index 1
        exp_rd(6'd1, 1'b1);
        tick();
        bus_if.lkp_valid = 1'b1;
        bus_if.lkp_pc    = 64'h8000_0040;
        #2 check("idle_lkp_ready", bus_if.lkp_ready, 1);
        tick();
        bus_if.lkp_valid = 1'b0;
        drain(20);

        // Taken saturating at 3, then not-taken decrement of slot 7, both at index 2
        exp_rd(6'd2, 1'b0);
        exp_wr(6'd2, 32'h0000_8003, 1'b1, 32'h1234, 8'h00);
        exp_rd(6'd2, 1'b0);
        exp_wr(6'd2, 32'h0000_4003, 1'b0, 32'h0, 8'h00);
        tick();
        bus_if.upd_valid  = 1'b1;
        bus_if.upd_pc     = 64'h80;
        bus_if.upd_taken  = 1'b1;
        bus_if.upd_target = 32'h1234;
        tick();
        bus_if.upd_pc     = 64'h9C;
        bus_if.upd_taken  = 1'b0;
        bus_if.upd_target = 32'h0;
        tick();
        bus_if.upd_valid  = 1'b0;
        drain(20);

        // Fill the FIFO under continuous lookups; the full FIFO forces the oldest update
        for (int i = 0; i < 4; i++) exp_rd(6'd5, 1'b1);
        exp_rd(6'd10, 1'b0);
        exp_wr(6'd10, 32'h0000_00C0, 1'b1, 32'hAAAA_0000, 8'h5A);
        exp_rd(6'd5, 1'b1);
        exp_rd(6'd5, 1'b1);
        exp_rd(6'd11, 1'b0);
        exp_wr(6'd11, 32'h0000_0000, 1'b0, 32'h0, 8'h00);
        exp_rd(6'd12, 1'b0);
        exp_wr(6'd12, 32'hC000_0000, 1'b1, 32'h0000_2000, 8'hFF);
        exp_rd(6'd13, 1'b0);
        exp_wr(6'd13, 32'h1235_5678, 1'b1, 32'hDEAD_BEE0, 8'h3C);
        for (int i = 0; i < 4; i++) begin
            tick();
            bus_if.lkp_valid  = 1'b1;
            bus_if.lkp_pc     = 64'h140;
            bus_if.upd_valid  = 1'b1;
            bus_if.upd_pc     = d_pc[i];
            bus_if.upd_taken  = d_tk[i];
            bus_if.upd_target = d_tgt[i];
        end
        tick();
        bus_if.upd_valid = 1'b0;
        #2;
        check("full_upd_ready", bus_if.upd_ready, 0);
        check("forced_lkp_ready", bus_if.lkp_ready, 0);
        repeat (3) tick();
        tick();
        bus_if.lkp_valid = 1'b0;
        drain(30);

        // One queued update against twelve cycles of continuous lookups at index 21
`ifdef UPD_STARVE_GUARD_EN
        for (int i = 0; i < 9; i++) exp_rd(6'd21, 1'b1);
        exp_rd(6'd20, 1'b0);
        exp_wr(6'd20, 32'h0000_0008, 1'b1, 32'h4444, 8'h11);
        exp_rd(6'd21, 1'b1);
`else
        for (int i = 0; i < 12; i++) exp_rd(6'd21, 1'b1);
        exp_rd(6'd20, 1'b0);
        exp_wr(6'd20, 32'h0000_0008, 1'b1, 32'h4444, 8'h11);
`endif
        for (int i = 0; i < 12; i++) begin
            tick();
            bus_if.lkp_valid  = 1'b1;
            bus_if.lkp_pc     = 64'h540;
            bus_if.upd_valid  = (i == 0);
            bus_if.upd_pc     = 64'h11504;
            bus_if.upd_taken  = 1'b1;
            bus_if.upd_target = 32'h4444;
        end
        tick();
        bus_if.lkp_valid = 1'b0;
        bus_if.upd_valid = 1'b0;
        drain(30);

        // Reset during the write cycle abandons the RMW and empties the FIFO
        exp_rd(6'd30, 1'b0);
        tick();
        bus_if.upd_valid  = 1'b1;
        bus_if.upd_pc     = 64'h780;
        bus_if.upd_taken  = 1'b1;
        bus_if.upd_target = 32'h77;
        tick();
        bus_if.upd_pc     = 64'h7C0;
        tick();
        bus_if.upd_valid  = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("rstwr_sram_we", sram_we, 0);
        check("rstwr_sram_en", sram_en, 0);
        check("rstwr_upd_ready", bus_if.upd_ready, 1);
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        check("post_rst_upd_ready", bus_if.upd_ready, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
